// File: rtl/demux_vc_if.sv
// Link-side and FIFO-side signals of the VC demultiplexer.
// The slave modport is the demux itself; master is the link source plus both FIFOs.
interface demux_vc_if #(
   parameter int unsigned DATA_SIZE = 6,
   parameter int unsigned CNT_SIZE  = 4
);
   logic                 valid_in;
   logic [DATA_SIZE-1:0] data_in;
   logic                 ready_in;
   logic                 full_vc0;
   logic                 full_vc1;
   logic                 push_vc0;
   logic                 push_vc1;
   logic [DATA_SIZE-1:0] data_vc0;
   logic [DATA_SIZE-1:0] data_vc1;
   logic [CNT_SIZE-1:0]  count_vc0;
   logic [CNT_SIZE-1:0]  count_vc1;

   modport slave (
      input  valid_in, data_in, full_vc0, full_vc1,
      output ready_in, push_vc0, push_vc1, data_vc0, data_vc1, count_vc0, count_vc1
   );

   modport master (
      output valid_in, data_in, full_vc0, full_vc1,
      input  ready_in, push_vc0, push_vc1, data_vc0, data_vc1, count_vc0, count_vc1
   );
endinterface

// File: rtl/demux_vc.sv
// Receive-side VC demultiplexer: steers each word to VC0/VC1 by its top bit,
// parking it in a one-entry hold register while the target FIFO is full.
module demux_vc #(
   parameter int unsigned DATA_SIZE = 6,
   parameter int unsigned CNT_SIZE  = 4
) (
   input  logic       clk,
   input  logic       reset,
   demux_vc_if.slave  bus
);

   typedef enum logic {PASS, HOLD} state_t;

   localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

   state_t               state;
   logic [DATA_SIZE-1:0] hold;
   logic                 in_vc;
   logic                 hold_vc;

   assign in_vc       = bus.data_in[DATA_SIZE-1];
   assign hold_vc     = hold[DATA_SIZE-1];
   // Pure state decode keeps ready_in free of any path from full_vcX or valid_in.
   assign bus.ready_in = (state == PASS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= PASS;
         hold          <= '0;
         bus.push_vc0  <= 1'b0;
         bus.push_vc1  <= 1'b0;
         bus.data_vc0  <= '0;
         bus.data_vc1  <= '0;
         bus.count_vc0 <= '0;
         bus.count_vc1 <= '0;
      end else begin
         bus.push_vc0 <= 1'b0;
         bus.push_vc1 <= 1'b0;
         case (state)
            PASS: begin
               if (bus.valid_in) begin
                  if (!in_vc) begin
                     if (!bus.full_vc0) begin
                        bus.push_vc0  <= 1'b1;
                        bus.data_vc0  <= bus.data_in;
                        bus.count_vc0 <= bus.count_vc0 + CNT_ONE;
                     end else begin
                        hold  <= bus.data_in;
                        state <= HOLD;
                     end
                  end else begin
                     if (!bus.full_vc1) begin
                        bus.push_vc1  <= 1'b1;
                        bus.data_vc1  <= bus.data_in;
                        bus.count_vc1 <= bus.count_vc1 + CNT_ONE;
                     end else begin
                        hold  <= bus.data_in;
                        state <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (!hold_vc && !bus.full_vc0) begin
                  bus.push_vc0  <= 1'b1;
                  bus.data_vc0  <= hold;
                  bus.count_vc0 <= bus.count_vc0 + CNT_ONE;
                  state         <= PASS;
               end else if (hold_vc && !bus.full_vc1) begin
                  bus.push_vc1  <= 1'b1;
                  bus.data_vc1  <= hold;
                  bus.count_vc1 <= bus.count_vc1 + CNT_ONE;
                  state         <= PASS;
               end
            end
            default: state <= PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_vc.sv
// Directed bench for demux_vc: reset, steering, stall, cross-VC independence,
// counter wrap and reset while holding a word.
module tb_demux_vc;

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   demux_vc_if #(.DATA_SIZE(6), .CNT_SIZE(4)) bus ();

   demux_vc #(.DATA_SIZE(6), .CNT_SIZE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.full_vc0 = 1'b0;
      bus.full_vc1 = 1'b0;
      step();
      step();
      chk("rst_ready", 32'(bus.ready_in), 32'd1);
      chk("rst_push0", 32'(bus.push_vc0), 32'd0);
      chk("rst_push1", 32'(bus.push_vc1), 32'd0);
      chk("rst_data0", 32'(bus.data_vc0), 32'h00);
      chk("rst_cnt1",  32'(bus.count_vc1), 32'd0);
      reset = 1'b0;

      // Steering: 0x05 to VC0 then 0x25 to VC1 back to back.
      bus.valid_in = 1'b1;
      bus.data_in  = 6'h05;
      step();
      chk("st_push0",  32'(bus.push_vc0), 32'd1);
      chk("st_push1a", 32'(bus.push_vc1), 32'd0);
      chk("st_data0",  32'(bus.data_vc0), 32'h05);
      chk("st_cnt0",   32'(bus.count_vc0), 32'd1);
      bus.data_in = 6'h25;
      step();
      chk("st_push1",  32'(bus.push_vc1), 32'd1);
      chk("st_push0b", 32'(bus.push_vc0), 32'd0);
      chk("st_data1",  32'(bus.data_vc1), 32'h25);
      chk("st_data0k", 32'(bus.data_vc0), 32'h05);
      chk("st_cnt1",   32'(bus.count_vc1), 32'd1);
      bus.valid_in = 1'b0;
      step();
      chk("st_idle0", 32'(bus.push_vc0), 32'd0);
      chk("st_idle1", 32'(bus.push_vc1), 32'd0);

      // Stall: 0x2A meets full_vc1, a VC0 word waits while stalled.
      bus.full_vc1 = 1'b1;
      bus.valid_in = 1'b1;
      bus.data_in  = 6'h2A;
      step();
      chk("sl_ready0", 32'(bus.ready_in), 32'd0);
      chk("sl_nopush", 32'(bus.push_vc1), 32'd0);
      bus.data_in = 6'h07;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sl_hold_rdy",  32'(bus.ready_in), 32'd0);
         chk("sl_hold_p0",   32'(bus.push_vc0), 32'd0);
         chk("sl_hold_p1",   32'(bus.push_vc1), 32'd0);
      end
      bus.full_vc1 = 1'b0;
      step();
      chk("sl_push1",  32'(bus.push_vc1), 32'd1);
      chk("sl_data1",  32'(bus.data_vc1), 32'h2A);
      chk("sl_cnt1",   32'(bus.count_vc1), 32'd2);
      chk("sl_ready1", 32'(bus.ready_in), 32'd1);
      chk("sl_push0",  32'(bus.push_vc0), 32'd0);
      bus.valid_in = 1'b0;
      step();
      chk("sl_single", 32'(bus.push_vc1), 32'd0);
      chk("sl_cnt0",   32'(bus.count_vc0), 32'd1);
      chk("sl_cnt1b",  32'(bus.count_vc1), 32'd2);

      // Cross-VC: full_vc0 does not block a VC1 word.
      bus.full_vc0 = 1'b1;
      bus.valid_in = 1'b1;
      bus.data_in  = 6'h3F;
      step();
      chk("xv_push1", 32'(bus.push_vc1), 32'd1);
      chk("xv_data1", 32'(bus.data_vc1), 32'h3F);
      chk("xv_cnt1",  32'(bus.count_vc1), 32'd3);
      chk("xv_ready", 32'(bus.ready_in), 32'd1);
      bus.valid_in = 1'b0;
      bus.full_vc0 = 1'b0;

      // Asynchronous reset mid-cycle while push_vc1 is high.
      reset = 1'b1;
      #1;
      chk("ar_push1", 32'(bus.push_vc1), 32'd0);
      chk("ar_data1", 32'(bus.data_vc1), 32'h00);
      chk("ar_cnt1",  32'(bus.count_vc1), 32'd0);
      chk("ar_cnt0",  32'(bus.count_vc0), 32'd0);
      chk("ar_ready", 32'(bus.ready_in), 32'd1);
      reset = 1'b0;

      // Wrap: 17 VC0 pushes on a 4-bit counter.
      bus.valid_in = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         bus.data_in = 6'(i % 32);
         step();
         if (i == 15) chk("wr_cnt15", 32'(bus.count_vc0), 32'd15);
         if (i == 16) chk("wr_cnt16", 32'(bus.count_vc0), 32'd0);
         if (i == 17) begin
            chk("wr_cnt17",  32'(bus.count_vc0), 32'd1);
            chk("wr_push17", 32'(bus.push_vc0), 32'd1);
            chk("wr_data17", 32'(bus.data_vc0), 32'h11);
            chk("wr_cnt1",   32'(bus.count_vc1), 32'd0);
         end
      end
      bus.valid_in = 1'b0;
      step();

      // Reset while holding 0x01 for VC0: the held word is dropped.
      bus.full_vc0 = 1'b1;
      bus.valid_in = 1'b1;
      bus.data_in  = 6'h01;
      step();
      chk("rh_ready0", 32'(bus.ready_in), 32'd0);
      bus.valid_in = 1'b0;
      reset = 1'b1;
      #1;
      chk("rh_ready1", 32'(bus.ready_in), 32'd1);
      chk("rh_cnt0a",  32'(bus.count_vc0), 32'd0);
      reset = 1'b0;
      step();
      bus.full_vc0 = 1'b0;
      step();
      chk("rh_push0a", 32'(bus.push_vc0), 32'd0);
      step();
      chk("rh_push0b", 32'(bus.push_vc0), 32'd0);
      chk("rh_cnt0b",  32'(bus.count_vc0), 32'd0);
      chk("rh_data0",  32'(bus.data_vc0), 32'h00);
      chk("rh_ready2", 32'(bus.ready_in), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_vc.md
# demux_vc

Virtual-channel demultiplexer for the receive side of the two-VC link. It takes a single stream of words, steers each word to the VC0 or VC1 FIFO according to its class bit, and emits registered push pulses. When the target FIFO signals full, it parks the word in a one-entry hold register and stalls the source. It is the inverse of the VC0/VC1 multiplexer and sits between the link input and the per-VC FIFOs.

## Interface
- DATA_SIZE, 6, word width in bits; bit DATA_SIZE-1 is the class bit.
- CNT_SIZE, 4, width of the per-VC push counters.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in carries a word this cycle.
- data_in  input  DATA_SIZE  incoming word.
- ready_in  output  1  block can accept a word this cycle. A word transfers when valid_in && ready_in at a rising edge.
- full_vc0  input  1  VC0 FIFO cannot take a push at the next edge (almost-full, one-slot margin).
- full_vc1  input  1  same, for VC1.
- push_vc0  output  1  registered one-cycle write strobe to the VC0 FIFO.
- push_vc1  output  1  registered one-cycle write strobe to the VC1 FIFO.
- data_vc0  output  DATA_SIZE  registered word for the VC0 FIFO.
- data_vc1  output  DATA_SIZE  registered word for the VC1 FIFO.
- count_vc0  output  CNT_SIZE  number of VC0 pushes, modulo 2^CNT_SIZE.
- count_vc1  output  CNT_SIZE  number of VC1 pushes, modulo 2^CNT_SIZE.

## Operation
- Destination VC = data_in[DATA_SIZE-1]: 0 selects VC0, 1 selects VC1. The full word, including the class bit, is forwarded unchanged.
- Two-state FSM: PASS and HOLD. Reset state is PASS.
- ready_in = (state == PASS). It is decoded from the state register only; there is no combinational path from full_vcX or valid_in.
- PASS, no transfer: push_vc0 = push_vc1 = 0; stay in PASS.
- PASS, transfer with full of the destination VC = 0: at that edge, set push_vcX = 1, load data_vcX = data_in, increment count_vcX; stay in PASS.
- PASS, transfer with full of the destination VC = 1: at that edge, load data_in into the hold register, push_vcX = 0; go to HOLD.
- HOLD, full of the held word's VC = 1: no push; stay in HOLD. Incoming data is ignored because ready_in = 0.
- HOLD, full of the held word's VC = 0: at that edge, push the held word (push_vcX = 1, data_vcX = held word, count_vcX++); go to PASS.
- The full flag of the non-destination VC never affects a decision.
- At most one of push_vc0 and push_vc1 is high in any cycle.
- data_vcX keeps its last pushed value while push_vcX = 0.
- Counters wrap from 2^CNT_SIZE-1 to 0 with no saturation.
- Reset values: state = PASS, ready_in = 1, push_vc0/1 = 0, data_vc0/1 = 0, count_vc0/1 = 0, hold register = 0.
- Reset asserted mid-HOLD discards the held word with no push. ready_in returns to 1 immediately (asynchronously).

## Timing
- Latency: a word accepted at edge k appears at the FIFO as push_vcX = 1 and data_vcX = word during cycle k..k+1. The FIFO captures it at edge k+1.
- Throughput: one word per clock while the destination full flags stay low. Back-to-back words may alternate VCs every cycle.
- Stall: a word that meets full at edge k is pushed at the first edge j > k at which its full_vcX is sampled low. ready_in is low from edge k to edge j and high again after edge j. A new word may be accepted at edge j+1.
- full_vcX is sampled only at the decision edge. The FIFO must assert it early enough that a push in the same cycle cannot overflow it.
- count_vcX updates at the same edge where push_vcX rises.

## Test plan
- Reset: assert reset mid-cycle with no clock edge. All outputs go to their reset values immediately, ready_in = 1.
- Steering (DATA_SIZE = 6): send 0x05 then 0x25 on consecutive cycles. Expect push_vc0 with data_vc0 = 0x05 one cycle after acceptance, then push_vc1 with data_vc1 = 0x25 on the next cycle; count_vc0 = count_vc1 = 1.
- Stall: full_vc1 = 1 while 0x2A is accepted. ready_in drops on the next cycle and no push occurs. Hold full_vc1 high for 3 cycles, then release: a single push_vc1 with 0x2A, ready_in = 1 again. valid_in words presented while stalled are not consumed.
- Cross-VC independence: full_vc0 = 1 while a VC1 word (0x3F) is sent. The push proceeds with no stall.
- Wrap: 17 VC0 pushes with CNT_SIZE = 4. count_vc0 reads 15, then 0, then 1.
- Reset in HOLD: enter HOLD with 0x01 on VC0, assert reset, release reset, then drop full_vc0. No push occurs and count_vc0 = 0.
